vc_arbiter: RTL and testbench
=============================

VC_ARBITER -- requirements
Module: vc_arbiter

Interface
REQ-001 SHALL have parameter: DATA_W, 6, bit width of one lane word.
REQ-002 SHALL have parameter: LANES, 4, number of virtual-channel input FIFOs; the design is fixed to 4.
REQ-003 SHALL have port: clk  in  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port: rst  in  1  reset, asynchronous and active-low.
REQ-005 SHALL have port: enb  in  1  advance enable; when 0, all state holds and pop/push are 0.
REQ-006 SHALL have port: iniciar  in  1  start request from flow-control fsm.
REQ-007 SHALL have port: empty  in  4  empty flag per lane FIFO.
REQ-008 SHALL have port: pausa  in  4  per-lane pause pulse from flow-control fsm.
REQ-009 SHALL have port: continuar  in  4  per-lane resume pulse from flow-control fsm.
REQ-010 SHALL have port: error_full  in  1  fatal overflow indication from flow-control fsm.
REQ-011 SHALL have port: out_full  in  1  destination FIFO cannot accept a word.
REQ-012 SHALL have port: data_in  in  4*DATA_W  lane read data, lane i at bits [i*DATA_W +: DATA_W].
REQ-013 SHALL have port: pop  out  4  one-hot read strobe to lane FIFOs.
REQ-014 SHALL have port: push  out  1  write strobe to destination FIFO.
REQ-015 SHALL have port: data_out  out  DATA_W  word written to destination.
REQ-016 SHALL have port: sel  out  2  lane index of the word on data_out.
REQ-017 SHALL have port: state  out  2  current state encoding.
REQ-018 SHALL have port: error  out  1  sticky error flag.

Function
REQ-019 SHALL implement states IDLE=0, ARB=1, HOLD=2, ERR=3.
REQ-020 SHALL transition IDLE->ARB on iniciar=1 with enb=1; IDLE ignores empty, pausa and continuar.
REQ-021 SHALL keep paused[3:0]: pausa[i] sets bit i, continuar[i] clears it, pausa wins when both are 1 in the same cycle; updated in ARB and HOLD only.
REQ-022 SHALL define eligible[i] = !empty[i] && !paused[i] using the registered paused value.
REQ-023 SHALL, in ARB with out_full=0 and any eligible, assert pop for exactly one lane chosen round-robin: first eligible lane after last_grant, searching upward modulo 4.
REQ-024 SHALL update last_grant only on a grant; last_grant resets to 3 so lane 0 has first priority.
REQ-025 SHALL register pop, so a grant decided in cycle N drives pop in cycle N+1 and never more than one bit.
REQ-026 SHALL assert push in the cycle after pop, with sel = popped lane and data_out = data_in slice of sel (combinational mux of the registered sel); pop-to-push latency is 1 cycle.
REQ-027 SHALL transition ARB->HOLD when out_full=1 or all lanes are paused; no pop is issued while in HOLD.
REQ-028 SHALL transition HOLD->ARB when out_full=0 and at least one lane is unpaused.
REQ-029 SHALL still complete a push already pending from a pop in the cycle out_full rises; the destination's almost-full margin covers this word.
REQ-030 SHALL enter ERR from ARB or HOLD on error_full=1, with priority over every other transition.
REQ-031 SHALL hold ERR with error=1 until reset; in ERR, pop=0, push=0 and a pending push is dropped.
REQ-032 SHALL, in ARB with no eligible lane and out_full=0, remain in ARB with pop=0.

Reset
REQ-033 SHALL, on rst=0 and immediately regardless of clk, force state=IDLE, paused=0, last_grant=3, pop=0, push=0, sel=0, error=0, and data_out=0 via sel=0 gating by push.
REQ-034 SHALL, when reset is asserted mid-transfer, drop the pending push with no partial word written.

Structure
REQ-035 SHALL place state encodings and LANES in a shared include, alongside the fsm's definitions.
REQ-036 SHALL put the round-robin grant logic in sub-module rr_select, with inputs eligible[3:0] and last[1:0], and outputs any and idx[1:0]; it SHALL be purely combinational.
REQ-037 SHALL be exercised by the vc_arbiter tester comparing the behavioural and synthesised netlists, with the same error-compare scheme as the fsm tester.

Verification
REQ-038 SHALL pass the test: reset, iniciar=1, empty=4'b0000, no pause, out_full=0 -> pop sequence 0001,0010,0100,1000,0001 on consecutive cycles; push follows 1 cycle later with sel 0,1,2,3.
REQ-039 SHALL pass the test: empty=4'b1010 -> pop alternates 0001,0100; lanes 1 and 3 are never popped.
REQ-040 SHALL pass the test: pausa=4'b0010 pulse, then pausa=4'b0010 together with continuar=4'b0010 in the same cycle -> lane 1 stays paused; a later continuar=4'b0010 alone -> lane 1 is granted within 4 cycles.
REQ-041 SHALL pass the test: out_full=1 during streaming -> state=HOLD next cycle, one trailing push, then pop=0; out_full=0 -> ARB, and round-robin resumes after last_grant.
REQ-042 SHALL pass the test: error_full=1 in HOLD -> state=3, error=1, pop=push=0; iniciar is ignored; only rst=0 returns to IDLE.
REQ-043 SHALL pass the test: rst=0 asynchronously mid-cycle while pop=0100 -> pop, push and error clear before the next clk edge; state=IDLE.

Source files
------------

// File: rtl/vc_arbiter_pkg.sv
// Shared definitions for the virtual-channel arbiter: lane count, FSM encoding
// and small lane index/one-hot helpers.
package vc_arbiter_pkg;

    localparam int NUM_LANES = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARB  = 2'd1,
        HOLD = 2'd2,
        ERR  = 2'd3
    } arbState_t;

    function automatic logic [3:0] laneOneHot(input logic [1:0] idx);
        laneOneHot = 4'b0001 << idx;
    endfunction

    function automatic logic [1:0] laneIndex(input logic [3:0] oneHot);
        laneIndex = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (oneHot[i]) begin
                laneIndex = 2'(i);
            end
        end
    endfunction

endpackage

// File: rtl/vc_arbiter_rr_select.sv
// Combinational round-robin pick: first eligible lane after 'last',
// searching upward modulo 4.
module rr_select (
    input  logic [3:0] eligible,
    input  logic [1:0] last,
    output logic       any,
    output logic [1:0] idx
);

    logic [1:0] cand;
    logic       found;

    always_comb begin
        any   = |eligible;
        idx   = last;
        cand  = last;
        found = 1'b0;
        // k = 4 wraps back to 'last' itself, so a lone eligible lane can be re-granted.
        for (int k = 1; k <= 4; k++) begin
            cand = last + 2'(k);
            if (!found && eligible[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vc_arbiter.sv
// Four-lane virtual-channel arbiter: round-robin pops from the lane FIFOs and
// forwards each popped word to the destination FIFO one cycle later.
module vc_arbiter
    import vc_arbiter_pkg::*;
#(
    parameter int DATA_W = 6,
    parameter int LANES  = NUM_LANES
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enb,
    input  logic                    iniciar,
    input  logic [LANES-1:0]        empty,
    input  logic [LANES-1:0]        pausa,
    input  logic [LANES-1:0]        continuar,
    input  logic                    error_full,
    input  logic                    out_full,
    input  logic [LANES*DATA_W-1:0] data_in,
    output logic [LANES-1:0]        pop,
    output logic                    push,
    output logic [DATA_W-1:0]       data_out,
    output logic [1:0]              sel,
    output logic [1:0]              state,
    output logic                    error
);

    arbState_t        stateReg;
    logic [LANES-1:0] pausedReg;
    logic [LANES-1:0] pausedNext;
    logic [LANES-1:0] eligible;
    logic [LANES-1:0] popReg;
    logic [1:0]       lastGrantReg;
    logic [1:0]       selReg;
    logic [1:0]       grantIdx;
    logic             pushReg;
    logic             errorReg;
    logic             anyEligible;
    logic             allPaused;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : gEligible
            assign eligible[gi] = ~empty[gi] & ~pausedReg[gi];
        end
    endgenerate

    // A pause arriving with a resume for the same lane wins.
    assign pausedNext = (pausedReg & ~continuar) | pausa;
    assign allPaused  = &pausedReg;

    rr_select uRrSelect (
        .eligible (eligible),
        .last     (lastGrantReg),
        .any      (anyEligible),
        .idx      (grantIdx)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateReg     <= IDLE;
            pausedReg    <= '0;
            lastGrantReg <= 2'd3;
            popReg       <= '0;
            pushReg      <= 1'b0;
            selReg       <= 2'd0;
            errorReg     <= 1'b0;
        end else if (enb) begin
            // Every pop turns into a push on the next cycle unless ERR drops it.
            popReg  <= '0;
            pushReg <= |popReg;
            if (|popReg) begin
                selReg <= laneIndex(popReg);
            end
            case (stateReg)
                IDLE: begin
                    if (iniciar) begin
                        stateReg <= ARB;
                    end
                end
                ARB: begin
                    pausedReg <= pausedNext;
                    if (error_full) begin
                        stateReg <= ERR;
                        errorReg <= 1'b1;
                        pushReg  <= 1'b0;
                    end else if (out_full || allPaused) begin
                        stateReg <= HOLD;
                    end else if (anyEligible) begin
                        popReg       <= laneOneHot(grantIdx);
                        lastGrantReg <= grantIdx;
                    end
                end
                HOLD: begin
                    pausedReg <= pausedNext;
                    if (error_full) begin
                        stateReg <= ERR;
                        errorReg <= 1'b1;
                        pushReg  <= 1'b0;
                    end else if (!out_full && !allPaused) begin
                        stateReg <= ARB;
                    end
                end
                ERR: begin
                    pushReg <= 1'b0;
                end
                default: begin
                    stateReg <= IDLE;
                end
            endcase
        end
    end

    // With enb low the whole datapath is frozen, so strobes are masked, not lost.
    assign pop      = popReg & {LANES{enb}};
    assign push     = pushReg & enb;
    assign sel      = selReg;
    assign state    = stateReg;
    assign error    = errorReg;
    assign data_out = push ? data_in[int'(selReg) * DATA_W +: DATA_W] : '0;

endmodule

// File: tb/tb_vc_arbiter.sv
// Directed bench for vc_arbiter: a cycle-by-cycle vector table for streaming,
// masking, pausing and back-pressure, plus sequences for enable, error and reset.
module tb_vc_arbiter;

    localparam int DW = 6;
    localparam logic [DW-1:0] L0 = 6'h05;
    localparam logic [DW-1:0] L1 = 6'h1A;
    localparam logic [DW-1:0] L2 = 6'h2C;
    localparam logic [DW-1:0] L3 = 6'h33;

    logic          clk;
    logic          rst;
    logic          enb;
    logic          iniciar;
    logic [3:0]    empty;
    logic [3:0]    pausa;
    logic [3:0]    continuar;
    logic          error_full;
    logic          out_full;
    logic [4*DW-1:0] data_in;
    logic [3:0]    pop;
    logic          push;
    logic [DW-1:0] data_out;
    logic [1:0]    sel;
    logic [1:0]    state;
    logic          error;

    int passCount = 0;
    int totalCount = 0;

    typedef struct {
        logic          ini;
        logic [3:0]    emp;
        logic [3:0]    pau;
        logic [3:0]    con;
        logic          ofull;
        logic [1:0]    expState;
        logic [3:0]    expPop;
        logic          expPush;
        logic [1:0]    expSel;
        logic [DW-1:0] expData;
    } vec_t;

    vec_t vecs[$];

    vc_arbiter #(.DATA_W(DW), .LANES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .enb        (enb),
        .iniciar    (iniciar),
        .empty      (empty),
        .pausa      (pausa),
        .continuar  (continuar),
        .error_full (error_full),
        .out_full   (out_full),
        .data_in    (data_in),
        .pop        (pop),
        .push       (push),
        .data_out   (data_out),
        .sel        (sel),
        .state      (state),
        .error      (error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        totalCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic addVec(input logic ini, input logic [3:0] emp, input logic [3:0] pau,
                          input logic [3:0] con, input logic ofull, input logic [1:0] st,
                          input logic [3:0] p, input logic ps, input logic [1:0] s,
                          input logic [DW-1:0] d);
        vec_t v;
        v.ini = ini; v.emp = emp; v.pau = pau; v.con = con; v.ofull = ofull;
        v.expState = st; v.expPop = p; v.expPush = ps; v.expSel = s; v.expData = d;
        vecs.push_back(v);
    endtask

    task automatic chkOut(input string tag, input logic [1:0] st, input logic [3:0] p,
                          input logic ps, input logic [1:0] s, input logic [DW-1:0] d);
        chk({tag, "_state"}, 32'(state), 32'(st));
        chk({tag, "_pop"},   32'(pop),   32'(p));
        chk({tag, "_push"},  32'(push),  32'(ps));
        chk({tag, "_sel"},   32'(sel),   32'(s));
        chk({tag, "_data"},  32'(data_out), 32'(d));
    endtask

    initial begin
        rst = 1'b0; enb = 1'b1; iniciar = 1'b0; empty = 4'hF; pausa = '0;
        continuar = '0; error_full = 1'b0; out_full = 1'b0;
        data_in = {L3, L2, L1, L0};

        // Streaming, masked lanes, back-pressure, pause/resume, all-paused, none eligible.
        //     ini  emp     pau     con     of   st  pop     ps  sel  data
        addVec(1, 4'b0000, 4'b0000, 4'b0000, 0, 1, 4'b0000, 0, 0, 6'h00); // 0
        addVec(0, 4'b0000, 4'b0000, 4'b0000, 0, 1, 4'b0001, 0, 0, 6'h00);
        addVec(0, 4'b0000, 4'b0000, 4'b0000, 0, 1, 4'b0010, 1, 0, L0);
        addVec(0, 4'b0000, 4'b0000, 4'b0000, 0, 1, 4'b0100, 1, 1, L1);
        addVec(0, 4'b0000, 4'b0000, 4'b0000, 0, 1, 4'b1000, 1, 2, L2);
        addVec(0, 4'b0000, 4'b0000, 4'b0000, 0, 1, 4'b0001, 1, 3, L3);    // 5
        addVec(0, 4'b1010, 4'b0000, 4'b0000, 0, 1, 4'b0100, 1, 0, L0);
        addVec(0, 4'b1010, 4'b0000, 4'b0000, 0, 1, 4'b0001, 1, 2, L2);
        addVec(0, 4'b1010, 4'b0000, 4'b0000, 0, 1, 4'b0100, 1, 0, L0);
        addVec(0, 4'b1010, 4'b0000, 4'b0000, 0, 1, 4'b0001, 1, 2, L2);
        addVec(0, 4'b0000, 4'b0000, 4'b0000, 0, 1, 4'b0010, 1, 0, L0);    // 10
        addVec(0, 4'b0000, 4'b0000, 4'b0000, 1, 2, 4'b0000, 1, 1, L1);
        addVec(0, 4'b0000, 4'b0000, 4'b0000, 1, 2, 4'b0000, 0, 1, 6'h00);
        addVec(0, 4'b0000, 4'b0000, 4'b0000, 0, 1, 4'b0000, 0, 1, 6'h00);
        addVec(0, 4'b0000, 4'b0000, 4'b0000, 0, 1, 4'b0100, 0, 1, 6'h00);
        addVec(0, 4'b0000, 4'b0000, 4'b0000, 0, 1, 4'b1000, 1, 2, L2);    // 15
        addVec(0, 4'b0000, 4'b0010, 4'b0000, 0, 1, 4'b0001, 1, 3, L3);
        addVec(0, 4'b0000, 4'b0010, 4'b0010, 0, 1, 4'b0100, 1, 0, L0);
        addVec(0, 4'b0000, 4'b0000, 4'b0000, 0, 1, 4'b1000, 1, 2, L2);
        addVec(0, 4'b0000, 4'b0000, 4'b0000, 0, 1, 4'b0001, 1, 3, L3);
        addVec(0, 4'b0000, 4'b0000, 4'b0000, 0, 1, 4'b0100, 1, 0, L0);    // 20
        addVec(0, 4'b0000, 4'b0000, 4'b0010, 0, 1, 4'b1000, 1, 2, L2);
        addVec(0, 4'b0000, 4'b0000, 4'b0000, 0, 1, 4'b0001, 1, 3, L3);
        addVec(0, 4'b0000, 4'b0000, 4'b0000, 0, 1, 4'b0010, 1, 0, L0);
        addVec(0, 4'b0000, 4'b1111, 4'b0000, 0, 1, 4'b0100, 1, 1, L1);
        addVec(0, 4'b0000, 4'b0000, 4'b0000, 0, 2, 4'b0000, 1, 2, L2);    // 25
        addVec(0, 4'b0000, 4'b0000, 4'b0000, 0, 2, 4'b0000, 0, 2, 6'h00);
        addVec(0, 4'b0000, 4'b0000, 4'b0001, 0, 2, 4'b0000, 0, 2, 6'h00);
        addVec(0, 4'b0000, 4'b0000, 4'b0000, 0, 1, 4'b0000, 0, 2, 6'h00);
        addVec(0, 4'b0000, 4'b0000, 4'b0000, 0, 1, 4'b0001, 0, 2, 6'h00);
        addVec(0, 4'b0000, 4'b0000, 4'b0000, 0, 1, 4'b0001, 1, 0, L0);    // 30
        addVec(0, 4'b1111, 4'b0000, 4'b1110, 0, 1, 4'b0000, 1, 0, L0);
        addVec(0, 4'b1111, 4'b0000, 4'b0000, 0, 1, 4'b0000, 0, 0, 6'h00);

        // Reset state while held in reset.
        #2;
        chkOut("reset", 2'd0, 4'b0000, 1'b0, 2'd0, 6'h00);
        chk("reset_error", 32'(error), 32'd0);
        #6 rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            iniciar   = vecs[i].ini;
            empty     = vecs[i].emp;
            pausa     = vecs[i].pau;
            continuar = vecs[i].con;
            out_full  = vecs[i].ofull;
            tick();
            chkOut($sformatf("v%0d", i), vecs[i].expState, vecs[i].expPop,
                   vecs[i].expPush, vecs[i].expSel, vecs[i].expData);
            $display("vec %0d: state=%0d pop=%b push=%b sel=%0d data_out=%h",
                     i, state, pop, push, sel, data_out);
        end
        pausa = '0; continuar = '0;

        // enb low masks strobes and freezes the machine.
        empty = 4'b0000;
        tick();
        chk("enb_pre_pop", 32'(pop), 32'b0010);
        enb = 1'b0;
        #1;
        chk("enb_off_pop", 32'(pop), 32'd0);
        chk("enb_off_push", 32'(push), 32'd0);
        tick();
        tick();
        chk("enb_hold_state", 32'(state), 32'd1);
        chk("enb_hold_pop", 32'(pop), 32'd0);
        enb = 1'b1;
        #1;
        chk("enb_resume_pop", 32'(pop), 32'b0010);
        tick();
        chkOut("enb_next", 2'd1, 4'b0100, 1'b1, 2'd1, L1);
        $display("enb seq: state=%0d pop=%b push=%b", state, pop, push);

        // Error raised while in HOLD; ERR is sticky and ignores iniciar.
        out_full = 1'b1;
        tick();
        chkOut("hold_in", 2'd2, 4'b0000, 1'b1, 2'd2, L2);
        tick();
        chk("hold_push_off", 32'(push), 32'd0);
        error_full = 1'b1; iniciar = 1'b1;
        tick();
        chk("err_state", 32'(state), 32'd3);
        chk("err_flag", 32'(error), 32'd1);
        chk("err_pop", 32'(pop), 32'd0);
        chk("err_push", 32'(push), 32'd0);
        error_full = 1'b0; out_full = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("err_sticky%0d_state", i), 32'(state), 32'd3);
            chk($sformatf("err_sticky%0d_flag", i), 32'(error), 32'd1);
            chk($sformatf("err_sticky%0d_pop", i), 32'(pop), 32'd0);
        end
        $display("err seq: state=%0d error=%b", state, error);
        #2 rst = 1'b0;
        #1;
        chk("err_rst_state", 32'(state), 32'd0);
        chk("err_rst_flag", 32'(error), 32'd0);
        iniciar = 1'b0;
        tick();
        rst = 1'b1;

        // Error while a push is pending: the word is dropped.
        iniciar = 1'b1;
        tick();
        chk("drop_arb", 32'(state), 32'd1);
        iniciar = 1'b0; empty = 4'b0000;
        tick();
        chk("drop_pop", 32'(pop), 32'b0001);
        error_full = 1'b1;
        tick();
        chk("drop_state", 32'(state), 32'd3);
        chk("drop_push", 32'(push), 32'd0);
        chk("drop_data", 32'(data_out), 32'd0);
        $display("drop seq: state=%0d push=%b", state, push);
        error_full = 1'b0;
        #2 rst = 1'b0;
        tick();
        rst = 1'b1;

        // Asynchronous reset mid-cycle while pop=0100.
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0; empty = 4'b1011;
        tick();
        chk("areset_pre_pop", 32'(pop), 32'b0100);
        #3 rst = 1'b0;
        #1;
        chk("areset_pop", 32'(pop), 32'd0);
        chk("areset_push", 32'(push), 32'd0);
        chk("areset_error", 32'(error), 32'd0);
        chk("areset_state", 32'(state), 32'd0);
        tick();
        chk("areset_held_push", 32'(push), 32'd0);
        rst = 1'b1; empty = 4'b0000;
        tick();
        chk("areset_after_state", 32'(state), 32'd0);
        chk("areset_after_push", 32'(push), 32'd0);
        $display("areset seq: state=%0d pop=%b push=%b", state, pop, push);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
